// File: rtl/equ_sym_buffer_if.sv
// equ_sym_buffer_if: write-side samples and equalizer-side handshake of equ_sym_buffer.
// With EQU_BUF_ERR_CNT_EN defined the interface also carries o_err_cnt.
interface equ_sym_buffer_if #(
    parameter int DATA_W = 16
);
    logic i_wr_en;
    logic [3:0] i_wr_add;
    logic [2:0] i_symbol_num;
    logic signed [DATA_W-1:0] i_re, i_im;
    logic i_rd_ready;
    logic o_rd_valid;
    logic [3:0] o_rd_add;
    logic [2:0] o_sym_num;
    logic signed [DATA_W-1:0] o_data_re, o_data_im, o_h_re, o_h_im;
    logic o_last;
    logic o_err;
`ifdef EQU_BUF_ERR_CNT_EN
    logic [7:0] o_err_cnt;
`endif
    modport master (
        output i_wr_en, i_wr_add, i_symbol_num, i_re, i_im, i_rd_ready,
        input o_rd_valid, o_rd_add, o_sym_num, o_data_re, o_data_im, o_h_re, o_h_im, o_last, o_err
`ifdef EQU_BUF_ERR_CNT_EN
        , input o_err_cnt
`endif
    );
    modport slave (
        input i_wr_en, i_wr_add, i_symbol_num, i_re, i_im, i_rd_ready,
        output o_rd_valid, o_rd_add, o_sym_num, o_data_re, o_data_im, o_h_re, o_h_im, o_last, o_err
`ifdef EQU_BUF_ERR_CNT_EN
        , output o_err_cnt
`endif
    );
endinterface

// File: rtl/equ_sym_buffer.sv
// equ_sym_buffer: holds NB-IoT data symbols until the pilot estimate is in, then streams data+h pairs.
// Define EQU_BUF_ERR_CNT_EN to add the saturating o_err_cnt drop counter.
module equ_sym_buffer #(
    parameter int DATA_W = 16
) (
    input logic i_clk_equ,
    input logic i_rst,
    equ_sym_buffer_if.slave bus
);
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_STREAM, R_DONE} rd_state_t;
    rd_state_t state;
    logic [2*DATA_W-1:0] data_mem [6][12];
    logic [2*DATA_W-1:0] pilot_mem [12];
    logic [5:0] full;
    logic pilot_done, rd_valid, err, is_pilot, wr_ok, drop, xfer;
    logic [2:0] wr_slot, rd_slot;
    logic [3:0] rd_sc;

    // Symbols 1,2,3,5,6,7 map onto slots 0..5; symbol 0 maps out of range and is rejected anyway.
    always_comb begin
        is_pilot = bus.i_symbol_num == 3'd4;
        wr_slot = bus.i_symbol_num < 3'd4 ? bus.i_symbol_num - 3'd1 : bus.i_symbol_num - 3'd2;
        wr_ok = bus.i_wr_en && bus.i_wr_add < 4'd12 && bus.i_symbol_num != 3'd0
            && (is_pilot ? !pilot_done : !full[wr_slot]);
        drop = bus.i_wr_en && !wr_ok;
        xfer = rd_valid && bus.i_rd_ready;
    end

    always_ff @(posedge i_clk_equ)
        if (wr_ok) begin
            if (is_pilot)
                pilot_mem[bus.i_wr_add] <= {bus.i_re, bus.i_im};
            else
                data_mem[wr_slot][bus.i_wr_add] <= {bus.i_re, bus.i_im};
        end

    always_ff @(posedge i_clk_equ or posedge i_rst)
        if (i_rst) begin
            state <= R_IDLE;
            full <= '0;
            pilot_done <= 1'b0;
            rd_valid <= 1'b0;
            rd_slot <= '0;
            rd_sc <= '0;
            err <= 1'b0;
        end else begin
            err <= drop;
            if (wr_ok && bus.i_wr_add == 4'd11) begin
                if (is_pilot)
                    pilot_done <= 1'b1;
                else
                    full[wr_slot] <= 1'b1;
            end
            case (state)
                R_IDLE: begin
                    rd_slot <= '0;
                    rd_sc <= '0;
                    if (pilot_done)
                        state <= R_WAIT;
                end
                R_WAIT:
                    if (full[rd_slot]) begin
                        state <= R_STREAM;
                        rd_valid <= 1'b1;
                    end
                R_STREAM:
                    if (xfer) begin
                        rd_sc <= rd_sc + 4'd1;
                        if (rd_sc == 4'd11) begin
                            full[rd_slot] <= 1'b0;
                            rd_sc <= '0;
                            rd_valid <= 1'b0;
                            rd_slot <= rd_slot == 3'd5 ? 3'd0 : rd_slot + 3'd1;
                            state <= rd_slot == 3'd5 ? R_DONE : R_WAIT;
                        end
                    end
                R_DONE: begin
                    pilot_done <= 1'b0;
                    state <= R_IDLE;
                end
            endcase
        end

`ifdef EQU_BUF_ERR_CNT_EN
    logic [7:0] err_cnt;
    always_ff @(posedge i_clk_equ or posedge i_rst)
        if (i_rst)
            err_cnt <= '0;
        else if (drop && err_cnt != 8'hff)
            err_cnt <= err_cnt + 8'd1;
    assign bus.o_err_cnt = err_cnt;
`endif

    always_comb begin
        bus.o_rd_valid = rd_valid;
        bus.o_rd_add = rd_valid ? rd_sc : 4'd0;
        bus.o_sym_num = rd_valid ? (rd_slot < 3'd3 ? rd_slot + 3'd1 : rd_slot + 3'd2) : 3'd0;
        {bus.o_data_re, bus.o_data_im} = rd_valid ? data_mem[rd_slot][rd_sc] : '0;
        {bus.o_h_re, bus.o_h_im} = rd_valid ? pilot_mem[rd_sc] : '0;
        bus.o_last = rd_valid && rd_slot == 3'd5 && rd_sc == 4'd11;
        bus.o_err = err;
    end
endmodule

// File: tb/tb_equ_sym_buffer.sv
// tb_equ_sym_buffer: random-valued frames against a queue-based reference of the slot buffer rules.
// Build with EQU_BUF_ERR_CNT_EN to also check o_err_cnt.
module tb_equ_sym_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    equ_sym_buffer_if #(.DATA_W(16)) bus ();
    equ_sym_buffer #(.DATA_W(16)) dut (.i_clk_equ(clk), .i_rst(rst), .bus(bus.slave));

    typedef struct {
        logic [2:0] sym;
        logic [3:0] sc;
        logic signed [15:0] dre, dim, hre, him;
        logic last;
    } beat_t;

    beat_t exp_q[$];
    int nchk, nerr;
    logic signed [15:0] m_re [8][12];
    logic signed [15:0] m_im [8][12];
    logic signed [15:0] m_pre [12];
    logic signed [15:0] m_pim [12];
    bit m_full [8];
    bit m_pd, pd_clr, pend_last, exp_err, stall, seen_last, seen5;
    int next_idx, pend_sym, m_cnt, rdy_mode;
    int ord [6] = '{1, 2, 3, 5, 6, 7};
    logic [63:0] snap_data;
    logic [7:0] snap_meta;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int sym, input int sc, input logic signed [15:0] re, input logic signed [15:0] im);
        bus.i_wr_en = 1'b1;
        bus.i_symbol_num = 3'(sym);
        bus.i_wr_add = 4'(sc);
        bus.i_re = re;
        bus.i_im = im;
        sync();
        bus.i_wr_en = 1'b0;
    endtask

    task automatic wr_sym(input int sym);
        for (int sc = 0; sc < 12; sc++)
            wr(sym, sc, 16'(sym * 16 + sc), 16'($urandom));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.o_rd_valid) && n < budget) begin
            sync();
            n++;
        end
        chk("drain_in_budget", n < budget, 1);
    endtask

    // Reference: a write lands only if in range, and its symbol (or the pilot) is not locked;
    // a symbol becomes readable once it and the pilot are complete, in fixed stream order.
    always @(posedge clk) begin : model
        bit acc;
        int s;
        beat_t b;
        if (rst) begin
            exp_q.delete();
            m_full = '{default: 0};
            m_pd = 0;
            pd_clr = 0;
            pend_last = 0;
            pend_sym = 0;
            next_idx = 0;
            exp_err = 0;
            m_cnt = 0;
        end else begin
            s = int'(bus.i_symbol_num);
            acc = bus.i_wr_en && bus.i_wr_add < 12 && s != 0 && (s == 4 ? !m_pd : !m_full[s]);
            exp_err = bus.i_wr_en && !acc;
            if (exp_err && m_cnt < 255)
                m_cnt++;
            if (acc && s == 4) begin
                m_pre[bus.i_wr_add] = bus.i_re;
                m_pim[bus.i_wr_add] = bus.i_im;
                if (bus.i_wr_add == 11)
                    m_pd = 1;
            end else if (acc) begin
                m_re[s][bus.i_wr_add] = bus.i_re;
                m_im[s][bus.i_wr_add] = bus.i_im;
                if (bus.i_wr_add == 11)
                    m_full[s] = 1;
            end
            if (pend_sym != 0)
                m_full[pend_sym] = 0;
            pend_sym = 0;
            if (pd_clr) begin
                m_pd = 0;
                next_idx = 0;
            end
            pd_clr = pend_last;
            pend_last = 0;
            while (m_pd && next_idx < 6 && m_full[ord[next_idx]]) begin
                for (int sc = 0; sc < 12; sc++) begin
                    b.sym = 3'(ord[next_idx]);
                    b.sc = 4'(sc);
                    b.dre = m_re[ord[next_idx]][sc];
                    b.dim = m_im[ord[next_idx]][sc];
                    b.hre = m_pre[sc];
                    b.him = m_pim[sc];
                    b.last = ord[next_idx] == 7 && sc == 11;
                    exp_q.push_back(b);
                end
                next_idx++;
            end
        end
    end

    always @(negedge clk) begin : monitor
        beat_t b;
        if (rst) begin
            chk("rst_valid", bus.o_rd_valid, 0);
`ifdef EQU_BUF_ERR_CNT_EN
            chk("rst_err_cnt", bus.o_err_cnt, 0);
`endif
            stall = 0;
        end else begin
            chk("err_pulse", bus.o_err, exp_err);
`ifdef EQU_BUF_ERR_CNT_EN
            chk("err_cnt", bus.o_err_cnt, m_cnt);
`endif
            if (stall) begin
                chk("stall_valid", bus.o_rd_valid, 1);
                chk("stall_meta", {bus.o_rd_add, bus.o_sym_num, bus.o_last}, snap_meta);
                chk("stall_data", {bus.o_data_re, bus.o_data_im, bus.o_h_re, bus.o_h_im}, snap_data);
            end
            if (!bus.o_rd_valid)
                chk("idle_zero", |{bus.o_rd_add, bus.o_sym_num, bus.o_last, bus.o_data_re,
                                   bus.o_data_im, bus.o_h_re, bus.o_h_im}, 0);
            else if (bus.i_rd_ready) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL beat_extra actual=sym%0d sc%0d required=no beat", bus.o_sym_num, bus.o_rd_add);
                end else begin
                    b = exp_q.pop_front();
                    nchk++;
                    if (bus.o_sym_num !== b.sym || bus.o_rd_add !== b.sc || bus.o_last !== b.last ||
                        bus.o_data_re !== b.dre || bus.o_data_im !== b.dim ||
                        bus.o_h_re !== b.hre || bus.o_h_im !== b.him) begin
                        nerr++;
                        $display("FAIL beat actual=sym%0d sc%0d d=%0d/%0d h=%0d/%0d last=%0b required=sym%0d sc%0d d=%0d/%0d h=%0d/%0d last=%0b",
                                 bus.o_sym_num, bus.o_rd_add, bus.o_data_re, bus.o_data_im, bus.o_h_re, bus.o_h_im, bus.o_last,
                                 b.sym, b.sc, b.dre, b.dim, b.hre, b.him, b.last);
                    end
                    if (b.sc == 11)
                        pend_sym = int'(b.sym);
                    if (b.last) begin
                        pend_last = 1;
                        seen_last = 1;
                    end
                    if (b.sym == 5)
                        seen5 = 1;
                end
            end
            stall = bus.o_rd_valid && !bus.i_rd_ready;
            snap_meta = {bus.o_rd_add, bus.o_sym_num, bus.o_last};
            snap_data = {bus.o_data_re, bus.o_data_im, bus.o_h_re, bus.o_h_im};
        end
    end

    initial begin
        bus.i_rd_ready = 1'b1;
        forever begin
            sync();
            bus.i_rd_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? !bus.i_rd_ready :
                             rdy_mode == 2 ? 1'($urandom) : 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        bus.i_wr_en = 1'b0;
        bus.i_wr_add = '0;
        bus.i_symbol_num = '0;
        bus.i_re = '0;
        bus.i_im = '0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_err", bus.o_err, 0);
        chk("reset_outputs", |{bus.o_rd_add, bus.o_sym_num, bus.o_last, bus.o_data_re, bus.o_h_re}, 0);
        sync();
        rst = 1'b0;

        // Frame 1: data 1..3 first, then pilot; latency and drop cases.
        wr_sym(1);
        wr_sym(2);
        wr_sym(3);
        wr(2, 5, 16'sh7fff, 16'sh1234);
        @(negedge clk);
        chk("rewrite_full_err", bus.o_err, 1);
        sync();
        for (int sc = 0; sc < 12; sc++)
            wr(4, sc, 16'(64 + sc), 16'($urandom));
        @(negedge clk);
        @(negedge clk);
        chk("latency_wait", bus.o_rd_valid, 0);
        @(negedge clk);
        chk("latency_valid", bus.o_rd_valid, 1);
        chk("first_h_re", bus.o_h_re, 64);
        chk("first_sym", bus.o_sym_num, 1);
        sync();
        wr(4, 3, 16'sh0bad, 16'sh0bad);
        @(negedge clk);
        chk("pilot_locked_err", bus.o_err, 1);
        sync();
        wr(5, 13, 16'sh0bad, 16'sh0bad);
        @(negedge clk);
        chk("bad_addr_err", bus.o_err, 1);
        sync();
        wr(0, 2, 16'sh0bad, 16'sh0bad);
        @(negedge clk);
        chk("sym0_err", bus.o_err, 1);
        sync();
        drain(200);

        // Rest of frame 1 under alternating back-pressure, then frame 2 right at the wrap.
        rdy_mode = 1;
        seen_last = 0;
        wr_sym(5);
        wr_sym(6);
        wr_sym(7);
        n = 0;
        while (!seen_last && n < 600) begin
            sync();
            n++;
        end
        chk("last_in_budget", n < 600, 1);
        wr(4, 0, 16'sh0040, 16'sh0111);
        @(negedge clk);
        chk("pilot_in_done_err", bus.o_err, 1);
        sync();
        wr(4, 0, 16'sh0040, 16'sh0222);
        @(negedge clk);
        chk("pilot_after_done_ok", bus.o_err, 0);
        sync();
        rdy_mode = 2;
        for (int sc = 1; sc < 12; sc++)
            wr(4, sc, 16'($urandom), 16'($urandom));
        foreach (ord[i])
            wr_sym(ord[i]);
        drain(1500);

        // Frame 3: reset while symbol 5 streams.
        rdy_mode = 0;
        seen5 = 0;
        wr(0, 0, 16'sh0, 16'sh0);
        wr_sym(1);
        wr_sym(2);
        wr_sym(3);
        for (int sc = 0; sc < 12; sc++)
            wr(4, sc, 16'($urandom), 16'($urandom));
        wr_sym(5);
        n = 0;
        while (!seen5 && n < 300) begin
            sync();
            n++;
        end
        chk("sym5_in_budget", n < 300, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_valid", bus.o_rd_valid, 0);
`ifdef EQU_BUF_ERR_CNT_EN
        chk("mid_reset_err_cnt", bus.o_err_cnt, 0);
`endif
        sync();
        sync();
        rst = 1'b0;

        // Saturation of the drop counter.
        for (int i = 0; i < 300; i++)
            wr(0, i % 16, 16'($urandom), 16'($urandom));
        @(negedge clk);
        chk("drop_run_err", bus.o_err, 1);
`ifdef EQU_BUF_ERR_CNT_EN
        chk("err_cnt_sat", bus.o_err_cnt, 255);
`endif
        sync();
        repeat (3) sync();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/equ_sym_buffer.md
# equ_sym_buffer

- Slot buffer between the equalizer write-address FSM and the complex equalizer datapath.
- Captures the 12 subcarriers of each NB-IoT uplink symbol at the write address supplied upstream.
- Holds data symbols 1-3 until pilot symbol 4 has delivered the channel estimate. Then streams every data subcarrier (symbols 1,2,3,5,6,7) with its matching estimate to the equalizer over a valid/ready handshake.

## Interface
- DATA_W, 16, signed width of each I or Q component
- i_clk_equ  in  1  equalizer clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_wr_en  in  1  sample valid from write side
- i_wr_add  in  4  subcarrier index 0..11
- i_symbol_num  in  3  symbol of current sample: 1,2,3,5,6,7 data; 4 pilot; 0 invalid
- i_re, i_im  in  DATA_W  sample I/Q
- i_rd_ready  in  1  equalizer accepts output
- o_rd_valid  out  1  output beat valid
- o_rd_add  out  4  subcarrier index of beat
- o_sym_num  out  3  symbol number of beat
- o_data_re, o_data_im  out  DATA_W  stored data sample
- o_h_re, o_h_im  out  DATA_W  pilot sample for same subcarrier
- o_last  out  1  beat is subcarrier 11 of symbol 7
- o_err  out  1  one-cycle pulse on a dropped write

## Operation
- Storage:
  - Data array of 6 slots x 12 entries x 2*DATA_W. Slot map: 1,2,3,5,6,7 -> 0..5.
  - Pilot array of 12 entries.
  - Flags: full[5:0] and pilot_done.
- Write rules (when i_wr_en=1):
  - symbol 4: write pilot[i_wr_add].
  - data symbol: write data[slot][i_wr_add].
  - Writing index 11 sets the matching flag at that edge.
- Dropped write (o_err=1 next cycle, no storage change):
  - i_wr_add>11, or i_symbol_num=0.
  - Target slot full bit set.
  - Pilot write while pilot_done=1.
- Read FSM states:
  - R_IDLE: rd_slot=0, rd_sc=0. Go to R_WAIT when pilot_done=1.
  - R_WAIT: go to R_STREAM when full[rd_slot]=1.
  - R_STREAM: o_rd_valid=1.
    - On a transfer (o_rd_valid & i_rd_ready), rd_sc increments.
    - On a transfer at rd_sc=11: clear full[rd_slot] and set rd_sc=0.
    - Then go to R_WAIT with rd_slot+1, or to R_DONE if rd_slot=5.
  - R_DONE: clear pilot_done and go to R_IDLE.
- Outputs in R_STREAM:
  - o_rd_add=rd_sc, o_sym_num=mapped symbol.
  - Data and h read from flop arrays at (rd_slot, rd_sc).
  - o_last = (rd_slot=5 & rd_sc=11).
  - All are 0 outside R_STREAM.
- Concurrency: writes to one slot while streaming another are allowed. Writes to the streaming slot are dropped, since it is full.

## Timing
- Reset: outputs 0, flags 0, FSM R_IDLE, pointers 0. Array contents are don't-care.
- Reset mid-stream aborts at once: o_rd_valid falls, partial symbols are discarded.
- Write-to-read latency:
  - Case: the edge k sets the last flag needed (pilot_done already set and full[rd_slot] set).
  - Edge k+1: FSM enters R_WAIT (from R_IDLE) or R_STREAM (from R_WAIT).
  - Worst case: o_rd_valid high after edge k+2.
- Throughput and back-pressure:
  - One beat per cycle while i_rd_ready=1.
  - Outputs hold stable while o_rd_valid=1 and i_rd_ready=0.
- Between symbols: minimum one R_WAIT cycle (o_rd_valid=0).
- Frame wrap: R_DONE lasts one cycle. A new pilot write in the R_DONE cycle is dropped; from the next cycle it is accepted.
- Flag clear wins over a same-edge rejected write. A write to a slot is accepted in the cycle after its last beat transfers.

## Configuration
- EQU_BUF_ERR_CNT_EN
  - Defined: adds output o_err_cnt, 8 bits. It is a saturating count of o_err pulses, reset to 0 and held at 255.
  - Undefined: port and counter absent. o_err behaviour unchanged.

## Test plan
- Write sym 1,2,3 (sc values sym*16+sc), then pilot 4, i_rd_ready=1 -> 36 beats in order. Symbol 1 sc 0 beat valid 2 cycles after pilot sc11 write; h_re equals pilot value.
- Toggle i_rd_ready 1/0 every cycle during streaming -> no beat lost or duplicated, outputs stable while stalled.
- Rewrite sym 2 sc 5 before it is read -> o_err pulse, original value read out.
- Also check a pilot write with pilot_done=1, i_wr_add=13, and i_symbol_num=0 -> each gives one o_err pulse.
- Full frame 1..7 -> o_last only on sym 7 sc 11. Second frame starting two cycles later streams correctly.
- Assert i_rst during sym 5 streaming -> o_rd_valid=0 next sample. With EQU_BUF_ERR_CNT_EN, o_err_cnt=0.
- 300 dropped writes -> o_err_cnt=255.
